reg_bank_arbiter: RTL and testbench
===================================

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per bank entry.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning bank entries; a power of two >= 2, with AW = log2(DEPTH).
REQ-003 The block SHALL have one clock and an asynchronous active-high reset, with ports: clk  input  1  rising-edge clock; reset  input  1  asynchronous, active-high.
REQ-004 The block SHALL have the requester ports: req0/req1  input  1  access request; we0/we1  input  1  1=write, 0=read; addr0/addr1  input  AW  entry index; wdata0/wdata1  input  WIDTH  write data.
REQ-005 The block SHALL have the response ports: gnt0/gnt1  output  1  one-cycle grant; rdata  output  WIDTH  read data; rvalid  output  1  rdata valid; rid  output  1  requester owning rdata; busy  output  1  transaction in progress.

Function
REQ-006 The block SHALL own a DEPTH x WIDTH register bank, written only through this arbiter.
REQ-007 The FSM SHALL have exactly three states: IDLE, GRANT, RESP; busy = (state != IDLE).
REQ-008 IDLE: req0/req1 SHALL be sampled only in IDLE; if any is high, the winner's we/addr/wdata SHALL be captured and the FSM SHALL go to GRANT; otherwise it SHALL stay in IDLE.
REQ-009 Winner selection: if a single request is high, that requester SHALL win; if both are high, the requester selected by 1-bit priority pointer ptr SHALL win.
REQ-010 ptr SHALL be set to the non-winning requester's index on every IDLE->GRANT transition.
REQ-011 GRANT: exactly the winner's gnt SHALL be 1 for this single cycle; gnt0 and gnt1 SHALL never be 1 together.
REQ-012 A write SHALL update bank[addr] at the clock edge ending GRANT.
REQ-013 A read SHALL load rdata from bank[addr] at that same edge; read-before-write inside a transaction is impossible because a transaction is either a write or a read.
REQ-014 RESP: rvalid SHALL be 1 only for read transactions, with rid = winner index; rdata SHALL hold its value until the next read completes.
REQ-015 The FSM SHALL go RESP->IDLE unconditionally; each transaction therefore takes 3 cycles, and the next arbitration occurs in the IDLE cycle that follows.
REQ-016 A requester SHALL drop req in the cycle after its gnt; a req still high in the next IDLE SHALL be treated as a new request.
REQ-017 req/we/addr/wdata changes during GRANT or RESP SHALL be ignored.
REQ-018 Read-after-write to the same address SHALL return the newly written value.

Reset
REQ-019 Asserting reset SHALL immediately force: state=IDLE, gnt0=gnt1=0, rvalid=0, rid=0, rdata=0, busy=0, ptr=0 (req0 favoured), and all bank entries = 0.
REQ-020 Reset during GRANT SHALL abort the write: the bank SHALL read back all-zero after reset.
REQ-021 The first arbitration SHALL occur in the first IDLE cycle after reset deasserts.

Configuration
REQ-022 With macro REG_BANK_PARITY_EN defined, each entry SHALL store an extra even-parity bit computed on write.
REQ-023 With REG_BANK_PARITY_EN defined, input err_inj (1 bit) SHALL, when high in the IDLE cycle that captures a write, store inverted parity for that write.
REQ-024 With REG_BANK_PARITY_EN defined, output perr (1 bit) SHALL be 1 together with rvalid when the recomputed parity mismatches, and SHALL be 0 otherwise and on reset.
REQ-025 Without REG_BANK_PARITY_EN, the err_inj and perr ports and the parity storage SHALL be absent; behaviour SHALL otherwise be identical.

Verification
REQ-026 Single write then read: req0 we0=1 addr0=2 wdata0=8'hA5, then req0 we0=0 addr0=2 -> gnt0 in cycles 2 and 5, rvalid=1 rid=0 rdata=8'hA5 in cycle 6.
REQ-027 Simultaneous requests after reset: req0 and req1 held high continuously -> grants in order gnt0, gnt1, gnt0, gnt1, 3 cycles apart.
REQ-028 Back-to-back cross access: req1 writes addr 3 = 8'h3C, then req0 reads addr 3 -> rvalid=1 rid=0 rdata=8'h3C.
REQ-029 Reset mid-operation: pulse reset in the GRANT cycle of a write of 8'hFF to addr 1 -> gnt and busy drop immediately, and a later read of addr 1 returns 8'h00.
REQ-030 Parity, with REG_BANK_PARITY_EN: write 8'h01 to addr 0 with err_inj=1, then read addr 0 -> rvalid=1 perr=1; a rewrite with err_inj=0 followed by a read -> perr=0.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// Two-requester arbiter in front of a DEPTH x WIDTH register bank, three cycles per transaction.
// Optional macro REG_BANK_PARITY_EN adds per-entry even parity with err_inj and perr ports.
module reg_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
`ifdef REG_BANK_PARITY_EN
    input  logic             err_inj,
    output logic             perr,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             rid,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               win_q, win_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [WIDTH-1:0]   bank_q [DEPTH];
    logic [WIDTH-1:0]   rdata_q;
    logic               rid_q;
    logic               winner;

    // A lone request wins outright; a tie goes to the requester named by ptr.
    assign winner = (req0 && req1) ? ptr_q : req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = GRANT;
                    win_d   = winner;
                    ptr_d   = ~winner;
                    we_d    = winner ? we1 : we0;
                    addr_d  = winner ? addr1 : addr0;
                    wdata_d = winner ? wdata1 : wdata0;
                end
            end
            GRANT:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The bank and read data commit at the edge that ends GRANT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
            rdata_q <= '0;
            rid_q   <= 1'b0;
        end else if (state_q == GRANT) begin
            if (we_q) begin
                bank_q[addr_q] <= wdata_q;
            end else begin
                rdata_q <= bank_q[addr_q];
                rid_q   <= win_q;
            end
        end
    end

`ifdef REG_BANK_PARITY_EN
    logic             errinj_q;
    logic             par_q [DEPTH];
    logic             perr_q;

    // Parity is computed from the captured write data; err_inj flips it to model a corrupt entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errinj_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) par_q[i] <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            if (state_q == IDLE) errinj_q <= err_inj;
            if (state_q == GRANT) begin
                if (we_q) par_q[addr_q] <= (^wdata_q) ^ errinj_q;
                else      perr_q        <= (^bank_q[addr_q]) != par_q[addr_q];
            end
        end
    end

    assign perr = rvalid && perr_q;
`endif

    assign gnt0   = (state_q == GRANT) && !win_q;
    assign gnt1   = (state_q == GRANT) && win_q;
    assign busy   = (state_q != IDLE);
    assign rvalid = (state_q == RESP) && !we_q;
    assign rid    = rid_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter (WIDTH=8, DEPTH=4).
// Parity scenario is compiled only when REG_BANK_PARITY_EN is defined.
module tb_reg_bank_arbiter;

    logic       clk;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [1:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid, rid, busy;
    logic [7:0] rdata;
`ifdef REG_BANK_PARITY_EN
    logic       err_inj;
    logic       perr;
`endif

    int compared   = 0;
    int mismatched = 0;

    reg_bank_arbiter #(.WIDTH(8), .DEPTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
`ifdef REG_BANK_PARITY_EN
        .err_inj(err_inj),
        .perr   (perr),
`endif
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .rdata  (rdata),
        .rvalid (rvalid),
        .rid    (rid),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request in the current IDLE cycle, then move into GRANT and scramble the inputs.
    task automatic issue(input logic who, input logic wr, input logic [1:0] a, input logic [7:0] d);
        if (who) begin
            req1 = 1'b1; we1 = wr; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = wr; addr0 = a; wdata0 = d;
        end
        step();
        req0 = 1'b0; req1 = 1'b0;
        we0 = ~we0; we1 = ~we1;
        addr0 = ~addr0; addr1 = ~addr1;
        wdata0 = ~wdata0; wdata1 = ~wdata1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
`ifdef REG_BANK_PARITY_EN
        err_inj = 0;
`endif
        reset = 1'b1;
        #2;
        compared += 5;
        if (busy !== 1'b0)   begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_gnt got %b%b want 00", gnt0, gnt1); end
        if (rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rvalid got %b want 0", rvalid); end
        if (rdata !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_rdata got %h want 00", rdata); end
        if (rid !== 1'b0)    begin mismatched++; $display("[TB] FAIL reset_rid got %b want 0", rid); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        issue(1'b0, 1'b1, 2'd2, 8'hA5);
        compared += 3;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_gnt got %b%b want 10", gnt0, gnt1); end
        if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_busy got %b want 1", busy); end
        step();
        if (rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_rvalid got %b want 0", rvalid); end
        step();
        compared += 4;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_idle_busy got %b want 0", busy); end
        issue(1'b0, 1'b0, 2'd2, 8'h00);
        if (gnt0 !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_gnt0 got %b want 1", gnt0); end
        step();
        if (rvalid !== 1'b1 || rid !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_valid_rid got %b/%b want 1/0", rvalid, rid); end
        if (rdata !== 8'hA5) begin mismatched++; $display("[TB] FAIL rd_data got %h want a5", rdata); end
        step();
        compared += 2;
        if (rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_idle_rvalid got %b want 0", rvalid); end
        if (rdata !== 8'hA5) begin mismatched++; $display("[TB] FAIL rd_hold got %h want a5", rdata); end
    endtask

    task automatic test_simultaneous();
        logic expWin;
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 2'd0; addr1 = 2'd1;
        for (int i = 0; i < 4; i++) begin
            expWin = i[0];
            step();
            compared += 3;
            if (gnt0 !== !expWin || gnt1 !== expWin) begin mismatched++; $display("[TB] FAIL sim_gnt%0d got %b%b want %b%b", i, gnt0, gnt1, !expWin, expWin); end
            if (gnt0 === 1'b1 && gnt1 === 1'b1) begin mismatched++; $display("[TB] FAIL sim_both%0d got 11 want one-hot", i); end
            step();
            if (rvalid !== 1'b1 || rid !== expWin) begin mismatched++; $display("[TB] FAIL sim_rid%0d got %b/%b want 1/%b", i, rvalid, rid, expWin); end
            step();
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 1'b1, 2'd3, 8'h3C);
        compared += 1;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_wgnt got %b%b want 01", gnt0, gnt1); end
        step();
        step();
        issue(1'b0, 1'b0, 2'd3, 8'h00);
        step();
        compared += 2;
        if (rvalid !== 1'b1 || rid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_rid got %b/%b want 1/0", rvalid, rid); end
        if (rdata !== 8'h3C) begin mismatched++; $display("[TB] FAIL b2b_data got %h want 3c", rdata); end
        step();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 1'b1, 2'd1, 8'hFF);
        compared += 3;
        if (gnt0 !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_gnt got %b want 1", gnt0); end
        reset = 1'b1;
        #2;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_gnt_drop got %b%b want 00", gnt0, gnt1); end
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_busy got %b want 0", busy); end
        #2;
        reset = 1'b0;
        step();
        issue(1'b0, 1'b0, 2'd1, 8'h00);
        step();
        compared += 2;
        if (rvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_rvalid got %b want 1", rvalid); end
        if (rdata !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_addr1 got %h want 00", rdata); end
        step();
        issue(1'b1, 1'b0, 2'd3, 8'h00);
        step();
        compared += 1;
        if (rdata !== 8'h00 || rid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_addr3 got %h/%b want 00/1", rdata, rid); end
        step();
    endtask

`ifdef REG_BANK_PARITY_EN
    task automatic test_parity();
        err_inj = 1'b1;
        issue(1'b0, 1'b1, 2'd0, 8'h01);
        err_inj = 1'b0;
        step();
        step();
        issue(1'b0, 1'b0, 2'd0, 8'h00);
        step();
        compared += 2;
        if (rvalid !== 1'b1 || perr !== 1'b1) begin mismatched++; $display("[TB] FAIL par_err got %b/%b want 1/1", rvalid, perr); end
        step();
        if (perr !== 1'b0) begin mismatched++; $display("[TB] FAIL par_idle got %b want 0", perr); end
        issue(1'b0, 1'b1, 2'd0, 8'h01);
        step();
        step();
        issue(1'b0, 1'b0, 2'd0, 8'h00);
        step();
        compared += 1;
        if (rvalid !== 1'b1 || perr !== 1'b0) begin mismatched++; $display("[TB] FAIL par_ok got %b/%b want 1/0", rvalid, perr); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
`ifdef REG_BANK_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
